// File: rtl/top.sv
// Single-cycle 32-bit MIPS subset core with a fixed test program in instruction ROM
// and a small word-addressed data memory; one instruction completes per clock.
module top #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writedata,
  output logic [31:0] dataadr,
  output logic        memwrite,
  output logic [31:0] readdata,
  output logic [7:0]  pclow
);

  localparam int IA_W     = $clog2(IMEM_WORDS);
  localparam int DA_W     = $clog2(DMEM_WORDS);
  localparam int PROG_LEN = 18;
  localparam logic [31:0] PROG [PROG_LEN] = '{
    32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025,
    32'h00642824, 32'h00a42820, 32'h10a7000a, 32'h0064202a,
    32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
    32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011,
    32'h20020001, 32'hac020054
  };

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  logic [31:0] r_pc;
  logic [31:0] r_rf   [32];
  logic [31:0] r_dmem [DMEM_WORDS] = '{default: '0};

  logic [31:0] w_rom  [IMEM_WORDS];
  logic [31:0] w_instr, w_sext, w_rd1, w_rd2, w_srcb, w_alu, w_wd;
  logic [31:0] w_pc4, w_pcbr, w_pcj, w_pcnext;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_wa;
  logic        w_regwrite, w_regdst, w_alusrc, w_memtoreg;
  logic        w_is_sw, w_is_beq, w_is_j;
  alu_op_e     w_aluop;
  logic        w_unused_ok;

  // ROM tail beyond the program reads as zero, which decodes as a no-op
  for (genvar g = 0; g < IMEM_WORDS; g++) begin : g_rom
    if (g < PROG_LEN) begin : g_prog
      assign w_rom[g] = PROG[g];
    end else begin : g_zero
      assign w_rom[g] = '0;
    end
  end

  assign w_instr = w_rom[r_pc[IA_W+1:2]];
  assign w_op    = w_instr[31:26];
  assign w_rs    = w_instr[25:21];
  assign w_rt    = w_instr[20:16];
  assign w_rd    = w_instr[15:11];
  assign w_funct = w_instr[5:0];
  assign w_sext  = {{16{w_instr[15]}}, w_instr[15:0]};

  always_comb begin
    w_regwrite = 1'b0;
    w_regdst   = 1'b0;
    w_alusrc   = 1'b0;
    w_memtoreg = 1'b0;
    w_is_sw    = 1'b0;
    w_is_beq   = 1'b0;
    w_is_j     = 1'b0;
    w_aluop    = ALU_ADD;
    case (w_op)
      6'h00: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        case (w_funct)
          6'h20:   w_aluop = ALU_ADD;
          6'h22:   w_aluop = ALU_SUB;
          6'h24:   w_aluop = ALU_AND;
          6'h25:   w_aluop = ALU_OR;
          6'h2A:   w_aluop = ALU_SLT;
          default: w_regwrite = 1'b0;
        endcase
      end
      6'h08: begin
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
      end
      6'h23: begin
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
        w_memtoreg = 1'b1;
      end
      6'h2B: begin
        w_alusrc = 1'b1;
        w_is_sw  = 1'b1;
      end
      6'h04: begin
        w_is_beq = 1'b1;
        w_aluop  = ALU_SUB;
      end
      6'h02:   w_is_j = 1'b1;
      default: ;
    endcase
  end

  assign w_rd1  = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
  assign w_rd2  = (w_rt == 5'd0) ? '0 : r_rf[w_rt];
  assign w_srcb = w_alusrc ? w_sext : w_rd2;

  always_comb begin
    w_alu = '0;
    case (w_aluop)
      ALU_ADD: w_alu = w_rd1 + w_srcb;
      ALU_SUB: w_alu = w_rd1 - w_srcb;
      ALU_AND: w_alu = w_rd1 & w_srcb;
      ALU_OR:  w_alu = w_rd1 | w_srcb;
      ALU_SLT: w_alu = {31'd0, $signed(w_rd1) < $signed(w_srcb)};
      default: w_alu = '0;
    endcase
  end

  assign dataadr   = w_alu;
  assign writedata = w_rd2;
  assign memwrite  = w_is_sw & ~reset;
  assign readdata  = r_dmem[dataadr[DA_W+1:2]];
  assign pclow     = r_pc[7:0];

  assign w_wa = w_regdst ? w_rd : w_rt;
  assign w_wd = w_memtoreg ? readdata : w_alu;

  assign w_pc4    = r_pc + 32'd4;
  assign w_pcbr   = w_pc4 + {w_sext[29:0], 2'b00};
  assign w_pcj    = {w_pc4[31:28], w_instr[25:0], 2'b00};
  assign w_pcnext = w_is_j ? w_pcj :
                    (w_is_beq && (w_rd1 == w_rd2)) ? w_pcbr : w_pc4;

  always_ff @(posedge clk) begin
    if (reset) r_pc <= '0;
    else       r_pc <= w_pcnext;
  end

  // Architectural state is kept across reset; only its update is suppressed
  always_ff @(posedge clk) begin
    if (!reset && w_regwrite && (w_wa != 5'd0)) r_rf[w_wa] <= w_wd;
  end

  always_ff @(posedge clk) begin
    if (memwrite) r_dmem[dataadr[DA_W+1:2]] <= writedata;
  end

  assign w_unused_ok = ^{dataadr[1:0], dataadr[31:DA_W+2], w_instr[10:6]};

endmodule

// File: tb/tb_top.sv
// Bench for the single-cycle MIPS core: directed program-trace checks plus
// random reset injection compared against an instruction-level model.
module tb_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] writedata, dataadr, readdata;
  logic        memwrite;
  logic [7:0]  pclow;

  int checks   = 0;
  int failures = 0;

  logic [31:0] prog  [64];
  logic [31:0] m_pc;
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];

  top #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .dataadr(dataadr),
    .memwrite(memwrite), .readdata(readdata), .pclow(pclow)
  );

  always #5 clk = ~clk;

  // Instruction-level reference: executes one instruction of the program image
  task automatic model_step(input logic rst);
    logic [31:0] ins, a, b, imm, pc4, res;
    logic [5:0]  op, fn;
    logic        wr;
    if (rst) begin
      m_pc = 32'd0;
      return;
    end
    ins = prog[m_pc[7:2]];
    op  = ins[31:26];
    fn  = ins[5:0];
    a   = m_reg[ins[25:21]];
    b   = m_reg[ins[20:16]];
    imm = {{16{ins[15]}}, ins[15:0]};
    pc4 = m_pc + 32'd4;
    m_pc = pc4;
    case (op)
      6'h00: begin
        wr  = 1'b1;
        res = 32'd0;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: wr = 1'b0;
        endcase
        if (wr && ins[15:11] != 5'd0) m_reg[ins[15:11]] = res;
      end
      6'h08: if (ins[20:16] != 5'd0) m_reg[ins[20:16]] = a + imm;
      6'h23: begin
        res = a + imm;
        if (ins[20:16] != 5'd0) m_reg[ins[20:16]] = m_mem[res[7:2]];
      end
      6'h2B: begin
        res = a + imm;
        m_mem[res[7:2]] = b;
      end
      6'h04: if (a == b) m_pc = pc4 + (imm << 2);
      6'h02: m_pc = {pc4[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
  endtask

  // Applies rst across one rising edge, advances the model, returns at the falling edge
  task automatic cyc(input logic rst);
    reset = rst;
    @(posedge clk);
    model_step(rst);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      checks++;
      if (pclow !== 8'h00) begin
        failures++;
        $display("FAIL reset_pclow cycle=%0d got=%h exp=00", i, pclow);
      end
      checks++;
      if (memwrite !== 1'b0) begin
        failures++;
        $display("FAIL reset_memwrite cycle=%0d got=%b exp=0", i, memwrite);
      end
    end
  endtask

  task automatic test_program();
    logic [7:0] exp_pc [16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                                8'h20, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h44};
    logic exp_mw;
    for (int c = 1; c <= 16; c++) begin
      if (c == 1) begin
        reset = 1'b0;
        #1;
      end else begin
        cyc(1'b0);
      end
      checks++;
      if (pclow !== exp_pc[c-1]) begin
        failures++;
        $display("FAIL prog_pclow cycle=%0d got=%h exp=%h", c, pclow, exp_pc[c-1]);
      end
      exp_mw = (c == 13) || (c == 16);
      checks++;
      if (memwrite !== exp_mw) begin
        failures++;
        $display("FAIL prog_memwrite cycle=%0d got=%b exp=%b", c, memwrite, exp_mw);
      end
      if (c == 13 || c == 14 || c == 16) begin
        checks++;
        if (dataadr !== ((c == 16) ? 32'd84 : 32'd80)) begin
          failures++;
          $display("FAIL prog_dataadr cycle=%0d got=%0d", c, dataadr);
        end
        checks++;
        if (((c == 14) ? readdata : writedata) !== 32'd7) begin
          failures++;
          $display("FAIL prog_data cycle=%0d got=%0d exp=7", c,
                   (c == 14) ? readdata : writedata);
        end
      end
    end
  endtask

  task automatic test_midreset();
    logic found = 1'b0;
    cyc(1'b1);
    cyc(1'b1);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pclow == 8'h14) found = 1'b1;
      else cyc(1'b0);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midreset_reach got=%h exp=14", pclow);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (memwrite !== 1'b0) begin
      failures++;
      $display("FAIL midreset_memwrite got=%b exp=0", memwrite);
    end
    cyc(1'b1);
    reset = 1'b0;
    #1;
    checks++;
    if (pclow !== 8'h00) begin
      failures++;
      $display("FAIL midreset_restart got=%h exp=00", pclow);
    end
    cyc(1'b0);
    checks++;
    if (pclow !== 8'h04) begin
      failures++;
      $display("FAIL midreset_next got=%h exp=04", pclow);
    end
  endtask

  task automatic test_random();
    logic        rst;
    logic [31:0] ins, ea;
    logic        is_sw, is_lw;
    for (int n = 0; n < 1000; n++) begin
      ins   = prog[m_pc[7:2]];
      is_sw = (ins[31:26] == 6'h2B);
      is_lw = (ins[31:26] == 6'h23);
      rst   = is_sw ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      reset = rst;
      #1;
      ea = m_reg[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
      checks++;
      if (pclow !== m_pc[7:0]) begin
        failures++;
        $display("FAIL rand_pclow n=%0d got=%h exp=%h", n, pclow, m_pc[7:0]);
      end
      checks++;
      if (memwrite !== (is_sw && !rst)) begin
        failures++;
        $display("FAIL rand_memwrite n=%0d got=%b exp=%b", n, memwrite, is_sw && !rst);
      end
      if (!rst && (is_sw || is_lw)) begin
        checks++;
        if (dataadr !== ea) begin
          failures++;
          $display("FAIL rand_dataadr n=%0d got=%h exp=%h", n, dataadr, ea);
        end
        checks++;
        if (is_sw && writedata !== m_reg[ins[20:16]]) begin
          failures++;
          $display("FAIL rand_writedata n=%0d got=%h exp=%h", n, writedata, m_reg[ins[20:16]]);
        end else if (is_lw && readdata !== m_mem[ea[7:2]]) begin
          failures++;
          $display("FAIL rand_readdata n=%0d got=%h exp=%h", n, readdata, m_mem[ea[7:2]]);
        end
      end
      @(posedge clk);
      model_step(rst);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] image [18] = '{
      32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025,
      32'h00642824, 32'h00a42820, 32'h10a7000a, 32'h0064202a,
      32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
      32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011,
      32'h20020001, 32'hac020054};
    for (int i = 0; i < 64; i++) begin
      prog[i]  = (i < 18) ? image[i] : 32'd0;
      m_mem[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_pc = 32'd0;
    @(negedge clk);
    test_reset();
    test_program();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 64, instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 64, data memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port writedata, output, 32, store data driven to data memory (rt register value).
REQ-006 SHALL have port dataadr, output, 32, data memory byte address (ALU result).
REQ-007 SHALL have port memwrite, output, 1, high during the cycle a sw executes.
REQ-008 SHALL have port readdata, output, 32, data memory read data at dataadr.
REQ-009 SHALL have port pclow, output, 8, PC[7:0] of the instruction currently executing.

Function
REQ-010 SHALL implement a single-cycle 32-bit MIPS core: one instruction fetched and completed per clock.
REQ-011 SHALL support add, sub, and, or, slt (R-type, opcode 0, funct 0x20/0x22/0x24/0x25/0x2A), lw (0x23), sw (0x2B), beq (0x04), addi (0x08), j (0x02); other opcodes execute as no-ops (no register or memory write, PC+4).
REQ-012 SHALL hold a 32x32 register file: two async reads, one write on rising edge; register 0 always reads 0 and ignores writes.
REQ-013 SHALL sign-extend 16-bit immediates for addi, lw, sw, beq; arithmetic wraps modulo 2^32, no overflow traps.
REQ-014 SHALL compute slt as signed comparison, result 1 or 0.
REQ-015 SHALL take beq when rs==rt: next PC = PC+4 + (signext(imm)<<2); otherwise PC+4.
REQ-016 SHALL compute j target as {PC+4[31:28], instr[25:0], 2'b00}.
REQ-017 SHALL read instruction memory combinationally, word index PC[7:2]; contents preloaded at elaboration with hex words (address 0 upward): 20020005 2003000c 2067fff7 00e22025 00642824 00a42820 10a7000a 0064202a 10800001 20050000 00e2202a 00853820 00e23822 ac670044 8c020050 08000011 20020001 ac020054; remaining words 0.
REQ-018 SHALL read data memory combinationally, word index dataadr[7:2]; write writedata on rising edge when memwrite; contents initialize to 0; low address bits ignored.
REQ-019 SHALL drive dataadr, writedata, memwrite, readdata combinationally from the current instruction.
REQ-020 SHALL write lw result (readdata) to rt; R-type result to rd; addi result to rt.

Reset
REQ-021 SHALL on rising edge with reset high set PC to 0; registers and data memory unchanged by reset.
REQ-022 SHALL suppress register-file and data-memory writes in any cycle reset is high.
REQ-023 SHALL output memwrite=0 and pclow=0 while reset is held (after first clock edge).
REQ-024 SHALL restart from PC 0 on reset asserted mid-program.

Verification
REQ-025 SHALL pass: reset high 3 cycles, release -> instruction at PC 0 executes first cycle, pclow=0x00, then 0x04, 0x08.
REQ-026 SHALL pass: run program -> first memwrite in 13th post-reset cycle with dataadr=80, writedata=7, pclow=0x34.
REQ-027 SHALL pass: continue -> lw cycle pclow=0x38, dataadr=80, readdata=7; next cycle j at pclow=0x3C; next pclow=0x44 (addi at 0x40 skipped).
REQ-028 SHALL pass: 16th post-reset cycle memwrite=1, dataadr=84, writedata=7; no memwrite to any address other than 80 and 84 before it.
REQ-029 SHALL pass: beq at 0x20 taken ($4=0) -> pclow skips 0x24 to 0x28; beq at 0x18 not taken -> 0x1C.
REQ-030 SHALL pass: assert reset for one cycle at pclow=0x14 -> next cycle pclow=0x00, no memwrite during reset cycle.
